// File: rtl/rob_multi_retire.sv
// rob_multi_retire: reorder buffer with multi-lane in-order allocate, multi-port
// out-of-order writeback and multi-lane in-order retire with precise exceptions.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   disp_valid/rd/has_rd     dispatch lanes (contiguous from lane 0)
//   disp_ready               room for a full DISPATCH_WIDTH group (registered count)
//   disp_idx                 ROB index offered to each dispatch lane (tail+lane)
//   wb_valid/idx/data/exc    execute writeback ports
//   ret_valid/we/rd/data     retire lanes to the architectural register file
//   flush                    excepting instruction retiring at head
//   count                    occupied entries
module rob_multi_retire #(
    parameter int NUM_ENTRIES    = 64,
    parameter int DISPATCH_WIDTH = 2,
    parameter int RETIRE_WIDTH   = 2,
    parameter int WB_PORTS       = 2,
    parameter int DATA_W         = 32,
    parameter int AREG_W         = 5,
    localparam int IDX_W         = $clog2(NUM_ENTRIES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DISPATCH_WIDTH-1:0]        disp_valid,
    input  logic [DISPATCH_WIDTH*AREG_W-1:0] disp_rd,
    input  logic [DISPATCH_WIDTH-1:0]        disp_has_rd,
    output logic                             disp_ready,
    output logic [DISPATCH_WIDTH*IDX_W-1:0]  disp_idx,
    input  logic [WB_PORTS-1:0]              wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]        wb_idx,
    input  logic [WB_PORTS*DATA_W-1:0]       wb_data,
    input  logic [WB_PORTS-1:0]              wb_exc,
    output logic [RETIRE_WIDTH-1:0]          ret_valid,
    output logic [RETIRE_WIDTH-1:0]          ret_we,
    output logic [RETIRE_WIDTH*AREG_W-1:0]   ret_rd,
    output logic [RETIRE_WIDTH*DATA_W-1:0]   ret_data,
    output logic                             flush,
    output logic [IDX_W:0]                   count
);

    // head/tail carry an extra wrap bit so full (count==NUM_ENTRIES) and empty differ
    logic [IDX_W:0]        head, tail;
    logic [IDX_W:0]        n_alloc, n_ret, free_slots;
    logic [NUM_ENTRIES-1:0] busy, done, exc, has_rd;
    logic [AREG_W-1:0]     rd_mem   [NUM_ENTRIES];
    logic [DATA_W-1:0]     data_mem [NUM_ENTRIES];
    logic                  alloc_en;

    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] alloc_idx;
    logic [RETIRE_WIDTH-1:0][IDX_W-1:0]   ret_idx;
    logic [RETIRE_WIDTH-1:0][AREG_W-1:0]  ret_rd_w;
    logic [RETIRE_WIDTH-1:0][DATA_W-1:0]  ret_data_w;

    assign count      = tail - head;
    assign free_slots = (IDX_W+1)'(NUM_ENTRIES) - count;
    // Registered count only: slots freed by this cycle's retire are not credited
    assign disp_ready = free_slots >= (IDX_W+1)'(DISPATCH_WIDTH);
    // A retiring exception squashes anything dispatched in the same cycle
    assign alloc_en   = disp_ready & ~flush;

    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_alloc
        assign alloc_idx[k] = tail[IDX_W-1:0] + IDX_W'(k);
    end
    for (genvar i = 0; i < RETIRE_WIDTH; i++) begin : g_ret
        assign ret_idx[i] = head[IDX_W-1:0] + IDX_W'(i);
    end

    assign disp_idx = alloc_idx;
    assign ret_rd   = ret_rd_w;
    assign ret_data = ret_data_w;

    // Retire window: contiguous run of busy&done entries from head. An excepting
    // entry ends the run; it retires itself only when it sits in lane 0.
    always_comb begin
        logic run;
        ret_valid  = '0;
        ret_we     = '0;
        ret_rd_w   = '0;
        ret_data_w = '0;
        flush      = 1'b0;
        run        = 1'b1;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (run && busy[ret_idx[i]] && done[ret_idx[i]]) begin
                if (exc[ret_idx[i]]) begin
                    if (i == 0) begin
                        ret_valid[0]  = 1'b1;
                        flush         = 1'b1;
                        ret_rd_w[0]   = rd_mem[ret_idx[0]];
                        ret_data_w[0] = data_mem[ret_idx[0]];
                    end
                    run = 1'b0;
                end else begin
                    ret_valid[i]  = 1'b1;
                    ret_we[i]     = has_rd[ret_idx[i]];
                    ret_rd_w[i]   = rd_mem[ret_idx[i]];
                    ret_data_w[i] = data_mem[ret_idx[i]];
                end
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        n_alloc = '0;
        n_ret   = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++)
            if (alloc_en && disp_valid[k]) n_alloc = n_alloc + (IDX_W+1)'(1);
        for (int i = 0; i < RETIRE_WIDTH; i++)
            if (ret_valid[i]) n_ret = n_ret + (IDX_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            busy <= '0;
            done <= '0;
            exc  <= '0;
        end else begin
            // Later ports override earlier ones on an index collision
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && busy[wb_idx[p*IDX_W +: IDX_W]]) begin
                    done[wb_idx[p*IDX_W +: IDX_W]]     <= 1'b1;
                    exc[wb_idx[p*IDX_W +: IDX_W]]      <= wb_exc[p];
                    data_mem[wb_idx[p*IDX_W +: IDX_W]] <= wb_data[p*DATA_W +: DATA_W];
                end
            end
            for (int i = 0; i < RETIRE_WIDTH; i++)
                if (ret_valid[i]) busy[ret_idx[i]] <= 1'b0;
            // disp_ready guarantees the allocation window never overlaps live entries
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (alloc_en && disp_valid[k]) begin
                    busy[alloc_idx[k]]   <= 1'b1;
                    done[alloc_idx[k]]   <= 1'b0;
                    exc[alloc_idx[k]]    <= 1'b0;
                    has_rd[alloc_idx[k]] <= disp_has_rd[k];
                    rd_mem[alloc_idx[k]] <= disp_rd[k*AREG_W +: AREG_W];
                end
            end
            head <= head + n_ret;
            tail <= tail + n_alloc;
        end
    end

endmodule

// File: tb/tb_rob_multi_retire.sv
module tb_rob_multi_retire;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  disp_valid, disp_has_rd;
    logic [9:0]  disp_rd;
    logic        disp_ready;
    logic [11:0] disp_idx;
    logic [1:0]  wb_valid, wb_exc;
    logic [11:0] wb_idx;
    logic [63:0] wb_data;
    logic [1:0]  ret_valid, ret_we;
    logic [9:0]  ret_rd;
    logic [63:0] ret_data;
    logic        flush;
    logic [6:0]  count;

    int checks = 0;
    int errors = 0;

    // bench-side model of what was dispatched
    logic [4:0] exp_rd [64];
    int         tb_tail = 0;
    int         anum    = 0;

    rob_multi_retire dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_has_rd(disp_has_rd),
        .disp_ready(disp_ready), .disp_idx(disp_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data), .wb_exc(wb_exc),
        .ret_valid(ret_valid), .ret_we(ret_we), .ret_rd(ret_rd), .ret_data(ret_data),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rd_of(input int a);
        return 5'((a * 7 + 3) % 32);
    endfunction

    // dispatch both lanes, recording expected rd per ROB index
    task automatic dispatch2(input logic [1:0] hr);
        disp_valid  = 2'b11;
        disp_has_rd = hr;
        disp_rd     = {rd_of(anum + 1), rd_of(anum)};
        exp_rd[tb_tail % 64]       = rd_of(anum);
        exp_rd[(tb_tail + 1) % 64] = rd_of(anum + 1);
        tick();
        disp_valid = 2'b00;
        tb_tail += 2;
        anum    += 2;
    endtask

    task automatic wb(input int p, input int idx, input logic [31:0] d, input logic e);
        wb_valid[p]          = 1'b1;
        wb_idx[p*6 +: 6]     = 6'(idx);
        wb_data[p*32 +: 32]  = d;
        wb_exc[p]            = e;
    endtask

    task automatic wb_clear();
        wb_valid = '0;
        wb_exc   = '0;
    endtask

    initial begin
        rst = 1'b1;
        disp_valid = '0; disp_has_rd = '0; disp_rd = '0;
        wb_valid = '0; wb_idx = '0; wb_data = '0; wb_exc = '0;
        tick(); tick();
        rst = 1'b0;

        // 1: reset state and three dispatch groups
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(disp_ready), 64'd1);
        chk("rst_ret_valid", 64'(ret_valid), 64'd0);
        chk("rst_ret_we", 64'(ret_we), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_ret_data", ret_data, 64'd0);
        chk("disp_idx0", 64'(disp_idx), 64'h040);
        dispatch2(2'b01);                  // idx1 does not write a register
        chk("disp_idx1", 64'(disp_idx), 64'h0C2);
        dispatch2(2'b11);
        chk("disp_idx2", 64'(disp_idx), 64'h144);
        dispatch2(2'b11);
        chk("count6", 64'(count), 64'd6);
        chk("empty_ret", 64'(ret_valid), 64'd0);

        // 2: out-of-order completion, in-order retire
        wb(0, 1, 32'h0000_1111, 1'b0);
        tick(); wb_clear();
        wb(1, 0, 32'h0000_AAAA, 1'b0);
        chk("ooo_hold", 64'(ret_valid), 64'd0);
        tick(); wb_clear();
        chk("ooo_ret_valid", 64'(ret_valid), 64'b11);
        chk("ooo_ret_we", 64'(ret_we), 64'b01);
        chk("ooo_ret_rd", 64'(ret_rd), 64'({exp_rd[1], exp_rd[0]}));
        chk("ooo_ret_data", ret_data, 64'h0000_1111_0000_AAAA);
        tick();
        chk("ooo_count", 64'(count), 64'd4);

        // 3: fill to capacity, blocked dispatch, ready returns one cycle after retire
        for (int c = 0; c < 30; c++) dispatch2(2'b11);
        chk("full_count", 64'(count), 64'd64);
        chk("full_ready", 64'(disp_ready), 64'd0);
        chk("full_disp_idx", 64'(disp_idx), 64'h0C2);
        disp_valid = 2'b11;
        tick();
        disp_valid = 2'b00;
        chk("full_ignored", 64'(count), 64'd64);
        wb(0, 2, 32'h2222_0002, 1'b0);
        wb(1, 3, 32'h3333_0003, 1'b0);
        tick(); wb_clear();
        chk("full_ret", 64'(ret_valid), 64'b11);
        chk("full_ready_nocredit", 64'(disp_ready), 64'd0);
        tick();
        chk("full_count62", 64'(count), 64'd62);
        chk("full_ready_back", 64'(disp_ready), 64'd1);

        // 4: drain up to head=63, then retire across the wrap point
        for (int n = 4; n <= 62; n += 2) begin
            wb(0, n, 32'hD000_0000 | 32'(n), 1'b0);
            if (n + 1 <= 62) wb(1, n + 1, 32'hD000_0000 | 32'(n + 1), 1'b0);
            tick(); wb_clear();
        end
        tick(); tick(); tick();
        chk("wrap_count3", 64'(count), 64'd3);
        chk("wrap_wait", 64'(ret_valid), 64'd0);
        wb(0, 63, 32'hCAFE_0063, 1'b0);
        wb(1, 0, 32'hBEEF_0000, 1'b0);
        tick(); wb_clear();
        chk("wrap_ret_valid", 64'(ret_valid), 64'b11);
        chk("wrap_ret_rd", 64'(ret_rd), 64'({exp_rd[0], exp_rd[63]}));
        chk("wrap_ret_data", ret_data, 64'hBEEF_0000_CAFE_0063);
        tick();
        chk("wrap_count1", 64'(count), 64'd1);
        chk("wrap_after", 64'(ret_valid), 64'd0);

        // 6: reset with in-flight entries and a concurrent writeback
        for (int c = 0; c < 5; c++) dispatch2(2'b11);
        chk("pre_rst_count", 64'(count), 64'd11);
        rst = 1'b1;
        wb(0, 1, 32'h5555_5555, 1'b0);
        tick(); wb_clear();
        rst = 1'b0;
        tb_tail = 0;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_ret", 64'(ret_valid), 64'd0);
        chk("mid_rst_ready", 64'(disp_ready), 64'd1);
        tick();
        chk("mid_rst_ret2", 64'(ret_valid), 64'd0);

        // 5: exception precise retire and flush
        dispatch2(2'b11);
        dispatch2(2'b11);
        wb(0, 0, 32'hA0, 1'b0);
        wb(1, 1, 32'hA1, 1'b0);
        tick(); wb_clear();
        wb(0, 2, 32'hE2, 1'b1);
        wb(1, 3, 32'hA3, 1'b0);
        chk("excA_ret", 64'(ret_valid), 64'b11);
        chk("excA_flush", 64'(flush), 64'd0);
        tick(); wb_clear();
        chk("excB_ret", 64'(ret_valid), 64'b01);
        chk("excB_we", 64'(ret_we), 64'b00);
        chk("excB_flush", 64'(flush), 64'd1);
        chk("excB_rd", 64'(ret_rd[4:0]), 64'(exp_rd[2]));
        chk("excB_count", 64'(count), 64'd2);
        disp_valid = 2'b11;                // must be squashed by the flush
        tick();
        disp_valid = 2'b00;
        tb_tail = 0;
        chk("post_flush_count", 64'(count), 64'd0);
        chk("post_flush_flag", 64'(flush), 64'd0);
        chk("post_flush_ret", 64'(ret_valid), 64'd0);
        chk("post_flush_idx", 64'(disp_idx), 64'h040);

        // writeback to a free entry is dropped; single-lane dispatch
        wb(0, 0, 32'h7777, 1'b0);
        tick(); wb_clear();
        disp_valid = 2'b01; disp_has_rd = 2'b01; disp_rd = 10'h013;
        tick();
        disp_valid = 2'b00;
        chk("one_lane_count", 64'(count), 64'd1);
        chk("stale_wb_ignored", 64'(ret_valid), 64'd0);
        wb(1, 0, 32'h1234_5678, 1'b0);
        tick(); wb_clear();
        chk("one_lane_ret", 64'(ret_valid), 64'b01);
        chk("one_lane_data", 64'(ret_data[31:0]), 64'h1234_5678);
        chk("one_lane_rd", 64'(ret_rd[4:0]), 64'h13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
